lin_master_frame_tx: RTL and testbench



---
 rtl/lin_pkg.sv | 48 ++++
 rtl/lin_master_frame_tx_if.sv | 25 ++
 rtl/lin_checksum_acc.sv | 29 ++
 rtl/lin_master_frame_tx.sv | 186 ++++++++++++++++++
 tb/tb_lin_master_frame_tx.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/lin_pkg.sv
// Shared LIN definitions: framed symbol constants, FSM encoding, diagnostic IDs
// and the PID / framing / checksum helpers used by the master TX and slave RX paths.
package lin_pkg;

  localparam logic [9:0] IDLE_SYM  = 10'h3FF;
  localparam logic [9:0] BREAK_SYM = 10'h000;
  localparam logic [9:0] DELIM_SYM = 10'h200;
  localparam logic [9:0] SYNC_SYM  = 10'h2AA;

  localparam int         LIN_IFS_CYCLES = 4;
  localparam logic [3:0] LIN_MAX_LEN    = 4'd8;

  // Diagnostic frames always carry a classic checksum.
  localparam logic [5:0] DIAG_ID_MREQ  = 6'h3C;
  localparam logic [5:0] DIAG_ID_SRESP = 6'h3D;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BRK,
    ST_DLM,
    ST_SYN,
    ST_PID,
    ST_DATA,
    ST_CHK,
    ST_RESP,
    ST_IFS
  } lin_state_e;

  function automatic logic [7:0] lin_pid(input logic [5:0] id);
    logic p0;
    logic p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  function automatic logic [9:0] lin_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // 8-bit add with end-around carry; the largest sum 0x1FE folds to 0xFF.
  function automatic logic [7:0] lin_csum_add(input logic [7:0] s, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, s} + {1'b0, b};
    return t[8] ? (t[7:0] + 8'd1) : t[7:0];
  endfunction

endpackage

// File: rtl/lin_master_frame_tx_if.sv
// Request/status bundle between the application layer and the master frame transmitter.
interface lin_master_frame_tx_if;

  logic        start;
  logic [5:0]  frame_id;
  logic        master_pub;
  logic [3:0]  data_len;
  logic        enhanced;
  logic [63:0] tx_data;
  logic [9:0]  data_out;
  logic        busy;
  logic        done;
  logic        len_err;

  modport master (
    output start, frame_id, master_pub, data_len, enhanced, tx_data,
    input  data_out, busy, done, len_err
  );

  modport slave (
    input  start, frame_id, master_pub, data_len, enhanced, tx_data,
    output data_out, busy, done, len_err
  );

endinterface

// File: rtl/lin_checksum_acc.sv
// Carry-wrapping LIN checksum accumulator; clear beats load beats add.
module lin_checksum_acc
  import lin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] init,
  input  logic       add_en,
  input  logic [7:0] add_byte,
  output logic [7:0] sum
);

  logic [7:0] sum_reg;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sum_reg <= 8'h00;
    end else if (load) begin
      sum_reg <= init;
    end else if (add_en) begin
      sum_reg <= lin_csum_add(sum_reg, add_byte);
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/lin_master_frame_tx.sv
// LIN master frame transmitter: break, delimiter, sync, PID, then data+checksum
// or a recessive slave-response window, followed by the inter-frame space.
module lin_master_frame_tx
  import lin_pkg::*;
#(
  parameter int IFS_CYCLES = LIN_IFS_CYCLES
)
(
  input  logic               clk,
  input  logic               reset,
  lin_master_frame_tx_if.slave bus
);

  localparam logic [3:0] IFS_LAST = 4'(IFS_CYCLES - 1);

  lin_state_e  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [9:0]  data_out_reg, data_out_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        len_err_reg, len_err_next;

  logic [5:0]  id_reg;
  logic        mpub_reg;
  logic [3:0]  len_reg;
  logic        enh_reg;
  logic [63:0] data_reg;

  logic        len_ok;
  logic        can_accept;
  logic        accept;
  logic [7:0]  pid;
  logic [7:0]  csum_init;
  logic        acc_load;
  logic        acc_add;
  logic [7:0]  cur_byte;
  logic [7:0]  acc_sum;
  logic [7:0]  data_bytes [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    assign data_bytes[gi] = data_reg[8*gi +: 8];
  end

  assign len_ok    = (bus.data_len != 4'd0) && (bus.data_len <= LIN_MAX_LEN);
  assign pid       = lin_pid(id_reg);
  assign csum_init = (enh_reg && (id_reg != DIAG_ID_MREQ) && (id_reg != DIAG_ID_SRESP))
                     ? pid : 8'h00;
  // Counter never exceeds 7 while in DATA, so the low bits index the byte directly.
  assign cur_byte  = data_bytes[cnt_next[2:0]];

  // The last IFS cycle doubles as an idle slot so a held start chains frames
  // with BREAK directly after the done cycle.
  assign can_accept = (state_reg == ST_IDLE) ||
                      ((state_reg == ST_IFS) && (cnt_reg == IFS_LAST));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    accept       = 1'b0;
    len_err_next = 1'b0;

    unique case (state_reg)
      ST_IDLE: state_next = ST_IDLE;
      ST_BRK:  state_next = ST_DLM;
      ST_DLM:  state_next = ST_SYN;
      ST_SYN:  state_next = ST_PID;
      ST_PID: begin
        state_next = mpub_reg ? ST_DATA : ST_RESP;
        cnt_next   = 4'd0;
      end
      ST_DATA: begin
        if (cnt_reg == len_reg - 4'd1) begin
          state_next = ST_CHK;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_CHK: begin
        state_next = ST_IFS;
        cnt_next   = 4'd0;
      end
      ST_RESP: begin
        if (cnt_reg == len_reg) begin
          state_next = ST_IFS;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_IFS: begin
        if (cnt_reg == IFS_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    if (can_accept && bus.start) begin
      if (len_ok) begin
        accept     = 1'b1;
        state_next = ST_BRK;
        cnt_next   = 4'd0;
      end else begin
        len_err_next = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so each symbol lines up with its state.
  always_comb begin
    data_out_next = IDLE_SYM;
    acc_load      = 1'b0;
    acc_add       = 1'b0;
    unique case (state_next)
      ST_BRK:  data_out_next = BREAK_SYM;
      ST_DLM:  data_out_next = DELIM_SYM;
      ST_SYN:  data_out_next = SYNC_SYM;
      ST_PID: begin
        data_out_next = lin_frame(pid);
        acc_load      = 1'b1;
      end
      ST_DATA: begin
        data_out_next = lin_frame(cur_byte);
        acc_add       = 1'b1;
      end
      ST_CHK:  data_out_next = lin_frame(~acc_sum);
      default: data_out_next = IDLE_SYM;
    endcase
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_IFS) && (cnt_next == IFS_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      data_out_reg <= IDLE_SYM;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      len_err_reg  <= 1'b0;
      id_reg       <= 6'd0;
      mpub_reg     <= 1'b0;
      len_reg      <= 4'd0;
      enh_reg      <= 1'b0;
      data_reg     <= 64'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      data_out_reg <= data_out_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      len_err_reg  <= len_err_next;
      if (accept) begin
        id_reg   <= bus.frame_id;
        mpub_reg <= bus.master_pub;
        len_reg  <= bus.data_len;
        enh_reg  <= bus.enhanced;
        data_reg <= bus.tx_data;
      end
    end
  end

  lin_checksum_acc u_csum (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .load     (acc_load),
    .init     (csum_init),
    .add_en   (acc_add),
    .add_byte (cur_byte),
    .sum      (acc_sum)
  );

  assign bus.data_out = data_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.len_err  = len_err_reg;

endmodule

// File: tb/tb_lin_master_frame_tx.sv
// Directed bench for lin_master_frame_tx: table of frames with hand-computed PID and
// checksum symbols, plus sequences for length errors, ignored starts, reset abort and chaining.
module tb_lin_master_frame_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  lin_master_frame_tx_if bus();

  lin_master_frame_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  id;
    logic        mpub;
    logic [3:0]  len;
    logic        enh;
    logic [63:0] data;
    logic [9:0]  pid_sym;
    logic [9:0]  chk_sym;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_req(input vec_t v);
    bus.frame_id   = v.id;
    bus.master_pub = v.mpub;
    bus.data_len   = v.len;
    bus.enhanced   = v.enh;
    bus.tx_data    = v.data;
  endtask

  // Runs one frame from a start pulse; optionally pulses start again at cycle 'glitch'.
  task automatic run_frame(input vec_t v, input string tag, input int glitch);
    logic [9:0] exp_q[$];
    logic [7:0] b;
    int n;
    exp_q = {10'h000, 10'h200, 10'h2AA, v.pid_sym};
    if (v.mpub) begin
      for (int k = 0; k < int'(v.len); k++) begin
        b = v.data[8*k +: 8];
        exp_q.push_back({1'b1, b, 1'b0});
      end
      exp_q.push_back(v.chk_sym);
    end else begin
      for (int k = 0; k <= int'(v.len); k++) exp_q.push_back(10'h3FF);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(10'h3FF);
    n = exp_q.size();

    drive_req(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.frame_id = ~v.id;
    bus.tx_data  = ~v.data;
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s sym%0d", tag, c), bus.data_out, exp_q[c]);
      check($sformatf("%s done%0d", tag, c), bus.done, (c == n - 1));
      check($sformatf("%s busy%0d", tag, c), bus.busy, 1'b1);
      if (c == glitch) begin
        bus.start    = 1'b1;
        bus.data_len = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check($sformatf("%s busy_after", tag), bus.busy, 1'b0);
    check($sformatf("%s idle_after", tag), bus.data_out, 10'h3FF);
    $display("frame %s id=%0h len=%0d pub=%0b: %0d symbols", tag, v.id, v.len, v.mpub, n);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    drive_req('{6'h00, 1'b0, 4'd0, 1'b0, 64'd0, 10'h000, 10'h000});

    vecs[0] = '{6'h10, 1'b1, 4'd2, 1'b1, 64'h0000_0000_0000_FFFF, 10'h2A0, 10'h35E};
    vecs[1] = '{6'h3C, 1'b1, 4'd8, 1'b1, 64'h0807_0605_0403_0201, 10'h278, 10'h3B6};
    vecs[2] = '{6'h10, 1'b0, 4'd4, 1'b1, 64'h0,                   10'h2A0, 10'h000};
    vecs[3] = '{6'h3D, 1'b1, 4'd1, 1'b1, 64'h80,                  10'h2FA, 10'h2FE};
    vecs[4] = '{6'h01, 1'b1, 4'd1, 1'b1, 64'h10,                  10'h382, 10'h25C};
    vecs[5] = '{6'h01, 1'b1, 4'd1, 1'b0, 64'h10,                  10'h382, 10'h3DE};
    vecs[6] = '{6'h00, 1'b1, 4'd3, 1'b0, 64'h0120F0,              10'h300, 10'h3DA};

    repeat (3) @(negedge clk);
    check("rst data_out", bus.data_out, 10'h3FF);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst len_err", bus.len_err, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i), -1);
      @(negedge clk);
    end

    // Invalid lengths: one-cycle len_err, no frame.
    for (int i = 0; i < 2; i++) begin
      drive_req(vecs[0]);
      bus.data_len = (i == 0) ? 4'd0 : 4'd9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("len%0d len_err", i), bus.len_err, 1'b1);
      check($sformatf("len%0d data_out", i), bus.data_out, 10'h3FF);
      check($sformatf("len%0d busy", i), bus.busy, 1'b0);
      @(negedge clk);
      check($sformatf("len%0d len_err_clr", i), bus.len_err, 1'b0);
      check($sformatf("len%0d still_idle", i), bus.data_out, 10'h3FF);
      $display("len_err test data_len=%0d", bus.data_len);
    end

    // A start pulse mid-DATA must not disturb the stream.
    run_frame(vecs[1], "glitch", 6);
    @(negedge clk);

    // Reset during DATA byte 3 aborts the frame without done.
    drive_req(vecs[1]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort pre byte3", bus.data_out, 10'h208);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort data_out", bus.data_out, 10'h3FF);
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet%0d", c), {bus.done, bus.busy, bus.data_out}, {2'b00, 10'h3FF});
    end
    $display("reset abort test complete");
    run_frame(vecs[0], "post_abort", -1);
    @(negedge clk);

    // Start held high: second BREAK directly after the first done.
    drive_req(vecs[0]);
    bus.start = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("b2b done", bus.done, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b break", bus.data_out, 10'h000);
    check("b2b busy", bus.busy, 1'b1);
    @(negedge clk);
    check("b2b delim", bus.data_out, 10'h200);
    cyc = 0;
    while (bus.busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b second frame ends", cyc < 30, 1'b1);
    $display("back-to-back test complete after %0d cycles", cyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
